// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } arb_src_e;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable counter: counts down to zero (access timing) or, with SAT_UP set,
// counts up and sticks at all-ones (stall statistics).
module arb_wait_counter #(
    parameter int WIDTH  = 4,
    parameter bit SAT_UP = 1'b0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (SAT_UP) begin
                if (count_q != '1) count_d = count_q + ONE;
            end else begin
                if (count_q != '0) count_d = count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;
    assign done  = SAT_UP ? (count_q == '1) : (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data stage.
// Define MEM_ARB_STATS_EN to add saturating per-requester stall counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY     = 2,
    parameter int DATA_STREAK_MAX = 4,
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              err
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_istall,
    output logic [15:0]       stat_dstall
`endif
);

    localparam int                  STREAK_W   = $clog2(DATA_STREAK_MAX + 2);
    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(DATA_STREAK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [CNT_W-1:0]    WAIT_LOAD  = CNT_W'(MEM_LATENCY - 1);

    arb_state_e          state_q, state_d;
    arb_src_e            src_q, src_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                drop_q, drop_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_pend_q, d_pend_d;
    logic                d_wr_prev_q, d_wr_prev_d;
    logic [ADDR_W-1:0]   d_addr_prev_q, d_addr_prev_d;

    logic             busy, grant, grant_data, src_req, fin, ack_ok;
    logic             wait_en, wait_done;
    logic [CNT_W-1:0] wait_cnt;

    assign busy       = (state_q == ARB_BUSY);
    assign grant      = !busy && (i_req || d_req);
    assign grant_data = d_req && !(i_req && (streak_q == STREAK_LIM));
    assign src_req    = (src_q == SRC_DATA) ? d_req : i_req;
    assign fin        = busy && wait_done;
    // An abandoned access still runs to completion but never acknowledges.
    assign ack_ok     = fin && src_req && !drop_q && !rst;
    assign i_ack      = ack_ok && (src_q == SRC_INSTR);
    assign d_ack      = ack_ok && (src_q == SRC_DATA);
    assign wait_en    = busy && (wait_cnt != '0);

    arb_wait_counter #(
        .WIDTH (CNT_W),
        .SAT_UP(1'b0)
    ) u_wait (
        .clk     (clk),
        .srst    (rst),
        .load    (grant),
        .load_val(WAIT_LOAD),
        .en      (wait_en),
        .count   (wait_cnt),
        .done    (wait_done)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        streak_d = streak_q;
        drop_d   = drop_q;
        if (!busy) begin
            drop_d = 1'b0;
            if (grant) begin
                state_d = ARB_BUSY;
                if (grant_data) begin
                    src_d    = SRC_DATA;
                    addr_d   = d_addr;
                    wr_d     = d_wr;
                    wdata_d  = d_wdata;
                    streak_d = i_req ? streak_q + STREAK_ONE : '0;
                end else begin
                    src_d    = SRC_INSTR;
                    addr_d   = i_addr;
                    wr_d     = 1'b0;
                    wdata_d  = '0;
                    streak_d = '0;
                end
            end
        end else begin
            if (!src_req) drop_d = 1'b1;
            if (fin)      state_d = ARB_IDLE;
        end
    end

    always_comb begin
        err_d = err_q;
        if (busy && !src_req) err_d = 1'b1;
        if (d_pend_q && d_req && ((d_wr != d_wr_prev_q) || (d_addr != d_addr_prev_q)))
            err_d = 1'b1;
        // Write to the address being fetched: flagged, data still goes first.
        if (i_req && d_req && d_wr && (d_addr == i_addr)) err_d = 1'b1;
    end

    assign d_pend_d      = d_req && !d_ack;
    assign d_wr_prev_d   = d_wr;
    assign d_addr_prev_d = d_addr;

    assign i_rdata   = i_ack ? mem_rdata : i_rdata_q;
    assign d_rdata   = (d_ack && !wr_q) ? mem_rdata : d_rdata_q;
    assign i_rdata_d = i_rdata;
    assign d_rdata_d = d_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            src_q         <= SRC_INSTR;
            addr_q        <= '0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            streak_q      <= '0;
            drop_q        <= 1'b0;
            err_q         <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            d_pend_q      <= 1'b0;
            d_wr_prev_q   <= 1'b0;
            d_addr_prev_q <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            addr_q        <= addr_d;
            wr_q          <= wr_d;
            wdata_q       <= wdata_d;
            streak_q      <= streak_d;
            drop_q        <= drop_d;
            err_q         <= err_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            d_pend_q      <= d_pend_d;
            d_wr_prev_q   <= d_wr_prev_d;
            d_addr_prev_q <= d_addr_prev_d;
        end
    end

    assign mem_en    = busy;
    assign mem_wr    = busy && wr_q;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign stall     = (i_req && !i_ack) || (d_req && !d_ack);
    assign err       = err_q;

`ifdef MEM_ARB_STATS_EN
    logic istall_full, dstall_full;

    arb_wait_counter #(
        .WIDTH (16),
        .SAT_UP(1'b1)
    ) u_istall (
        .clk     (clk),
        .srst    (rst),
        .load    (1'b0),
        .load_val(16'h0000),
        .en      (i_req && !i_ack && !istall_full),
        .count   (stat_istall),
        .done    (istall_full)
    );

    arb_wait_counter #(
        .WIDTH (16),
        .SAT_UP(1'b1)
    ) u_dstall (
        .clk     (clk),
        .srst    (rst),
        .load    (1'b0),
        .load_val(16'h0000),
        .en      (d_req && !d_ack && !dstall_full),
        .count   (stat_dstall),
        .done    (dstall_full)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 time unit after posedge,
// outputs are sampled on the following negedge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        err;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_istall;
    logic [15:0] stat_dstall;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall    (stall),
        .err      (err)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_istall(stat_istall),
        .stat_dstall(stat_dstall)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, expected finish before 50000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;

        // Reset state
        repeat (2) next_cycle();
        sample();
        check1("rst_mem_en", mem_en, 1'b0);
        check1("rst_i_ack", i_ack, 1'b0);
        check1("rst_d_ack", d_ack, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_stall", stall, 1'b0);
        check16("rst_i_rdata", i_rdata, 16'h0000);
        check16("rst_d_rdata", d_rdata, 16'h0000);
        check16("rst_mem_addr", mem_addr, 16'h0000);
        next_cycle(); rst = 1'b0;
        $display("step reset: done");

        // T1: lone instruction fetch
        next_cycle(); i_req = 1'b1; i_addr = 16'h0040; mem_rdata = 16'hA5A5;
        sample();
        check1("t1_c0_mem_en", mem_en, 1'b0);
        check1("t1_c0_stall", stall, 1'b1);
        next_cycle(); sample();
        check1("t1_c1_mem_en", mem_en, 1'b1);
        check16("t1_c1_mem_addr", mem_addr, 16'h0040);
        check1("t1_c1_i_ack", i_ack, 1'b0);
        check1("t1_c1_stall", stall, 1'b1);
        next_cycle(); sample();
        check1("t1_c2_mem_en", mem_en, 1'b1);
        check1("t1_c2_i_ack", i_ack, 1'b1);
        check16("t1_c2_i_rdata", i_rdata, 16'hA5A5);
        check1("t1_c2_stall", stall, 1'b0);
        next_cycle(); i_req = 1'b0; sample();
        check1("t1_c3_mem_en", mem_en, 1'b0);
        check1("t1_c3_i_ack", i_ack, 1'b0);
        check16("t1_c3_i_rdata_hold", i_rdata, 16'hA5A5);
        $display("step t1 lone fetch: done");

        // T2: simultaneous requests, data first
        next_cycle(); i_req = 1'b1; i_addr = 16'h0050; d_req = 1'b1; d_wr = 1'b0;
        d_addr = 16'h0100; mem_rdata = 16'h1111;
        sample();
        check1("t2_c0_mem_en", mem_en, 1'b0);
        next_cycle(); sample();
        check16("t2_c1_mem_addr", mem_addr, 16'h0100);
        check1("t2_c1_mem_wr", mem_wr, 1'b0);
        next_cycle(); sample();
        check1("t2_c2_d_ack", d_ack, 1'b1);
        check1("t2_c2_i_ack", i_ack, 1'b0);
        check16("t2_c2_d_rdata", d_rdata, 16'h1111);
        check1("t2_c2_stall", stall, 1'b1);
        next_cycle(); d_req = 1'b0; sample();
        check1("t2_c3_mem_en", mem_en, 1'b0);
        check1("t2_c3_d_ack", d_ack, 1'b0);
        check1("t2_c3_stall", stall, 1'b1);
        next_cycle(); mem_rdata = 16'h2222; sample();
        check1("t2_c4_mem_en", mem_en, 1'b1);
        check16("t2_c4_mem_addr", mem_addr, 16'h0050);
        next_cycle(); sample();
        check1("t2_c5_i_ack", i_ack, 1'b1);
        check16("t2_c5_i_rdata", i_rdata, 16'h2222);
        check16("t2_c5_d_rdata_hold", d_rdata, 16'h1111);
        next_cycle(); i_req = 1'b0; sample();
        check1("t2_c6_mem_en", mem_en, 1'b0);
        $display("step t2 data priority: done");

        // T3: data streak capped at 4 while instruction waits
        next_cycle(); i_req = 1'b1; i_addr = 16'h0060; d_req = 1'b1; d_wr = 1'b0;
        d_addr = 16'h0300; mem_rdata = 16'h3333;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            next_cycle();
            sample();
            check1($sformatf("t3_access%0d_d_ack", k), d_ack, (k == 4) ? 1'b0 : 1'b1);
            check1($sformatf("t3_access%0d_i_ack", k), i_ack, (k == 4) ? 1'b1 : 1'b0);
            $display("step t3 access %0d: d_ack=%b i_ack=%b", k, d_ack, i_ack);
            next_cycle();
        end
        i_req = 1'b0; d_req = 1'b0;
        sample();
        check1("t3_end_mem_en", mem_en, 1'b0);
        check1("t3_end_err", err, 1'b0);

        // T4: data write
        next_cycle(); d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        sample();
        check1("t4_c0_mem_wr", mem_wr, 1'b0);
        next_cycle(); sample();
        check1("t4_c1_mem_wr", mem_wr, 1'b1);
        check16("t4_c1_mem_wdata", mem_wdata, 16'h1234);
        check16("t4_c1_mem_addr", mem_addr, 16'h0200);
        check1("t4_c1_d_ack", d_ack, 1'b0);
        next_cycle(); sample();
        check1("t4_c2_mem_wr", mem_wr, 1'b1);
        check16("t4_c2_mem_wdata", mem_wdata, 16'h1234);
        check1("t4_c2_d_ack", d_ack, 1'b1);
        check16("t4_c2_d_rdata_hold", d_rdata, 16'h3333);
        next_cycle(); d_req = 1'b0; d_wr = 1'b0; sample();
        check1("t4_c3_mem_wr", mem_wr, 1'b0);
        check1("t4_c3_d_ack", d_ack, 1'b0);
        check1("t4_c3_err", err, 1'b0);
        $display("step t4 write: done");

        // T5: data request dropped mid-access
        next_cycle(); d_req = 1'b1; d_addr = 16'h0400; sample();
        check1("t5_c0_err", err, 1'b0);
        next_cycle(); d_req = 1'b0; sample();
        check1("t5_c1_mem_en", mem_en, 1'b1);
        next_cycle(); sample();
        check1("t5_c2_err", err, 1'b1);
        check1("t5_c2_d_ack", d_ack, 1'b0);
        check1("t5_c2_mem_en", mem_en, 1'b1);
        next_cycle(); sample();
        check1("t5_c3_mem_en", mem_en, 1'b0);
        check1("t5_c3_err", err, 1'b1);
        next_cycle(); sample();
        check1("t5_c4_err_sticky", err, 1'b1);
        $display("step t5 dropped request: done");

        // T6: reset in the middle of an access
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0; sample();
        check1("t6_clr_err", err, 1'b0);
        check16("t6_clr_i_rdata", i_rdata, 16'h0000);
        next_cycle(); i_req = 1'b1; i_addr = 16'h0070; mem_rdata = 16'h7777;
        next_cycle(); rst = 1'b1; i_req = 1'b0; sample();
        check1("t6_busy_mem_en", mem_en, 1'b1);
        check1("t6_busy_i_ack", i_ack, 1'b0);
        next_cycle(); rst = 1'b0; sample();
        check1("t6_post_mem_en", mem_en, 1'b0);
        check16("t6_post_mem_addr", mem_addr, 16'h0000);
        check1("t6_post_i_ack", i_ack, 1'b0);
        check1("t6_post_err", err, 1'b0);
        check1("t6_post_stall", stall, 1'b0);
        next_cycle(); sample();
        check1("t6_later_i_ack", i_ack, 1'b0);
        check1("t6_later_mem_en", mem_en, 1'b0);
        $display("step t6 reset mid-busy: done");

        // T7: write to the fetch address is flagged but data still wins
        next_cycle(); i_req = 1'b1; i_addr = 16'h0080; d_req = 1'b1; d_wr = 1'b1;
        d_addr = 16'h0080; d_wdata = 16'h5A5A;
        sample();
        check1("t7_c0_err", err, 1'b0);
        next_cycle(); sample();
        check1("t7_c1_err", err, 1'b1);
        check1("t7_c1_mem_wr", mem_wr, 1'b1);
        check16("t7_c1_mem_addr", mem_addr, 16'h0080);
        next_cycle(); sample();
        check1("t7_c2_d_ack", d_ack, 1'b1);
        check1("t7_c2_i_ack", i_ack, 1'b0);
        next_cycle(); i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; sample();
        check1("t7_c3_mem_en", mem_en, 1'b0);
        $display("step t7 hazard: done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences one shared single-ported memory between two requesters: instruction fetch (read-only) and data memory stage (read/write).
- Sits between the fetch/data_mem units and the memory macro.
- Owns grant selection, multi-cycle access timing, ack generation, and stall signalling to the processor top.
- Fixed data-over-instruction priority, with an anti-starvation cap.

Parameters:
- MEM_LATENCY, 2, cycles a memory access occupies the port (legal 1..15).
- DATA_STREAK_MAX, 4, max consecutive data grants while an instruction request waits.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  ADDR_W  instruction address.
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  DATA_W  instruction read data.
- d_req  in  1  data request; held until d_ack.
- d_wr  in  1  1=write, 0=read; stable while d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle for reads.
- d_rdata  out  DATA_W  data read data.
- mem_en  out  1  memory access active.
- mem_wr  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid on the final access cycle.
- stall  out  1  high when any request is pending and not acked this cycle.
- err  out  1  protocol violation flag (sticky until rst).

Behaviour:
- Reset: all outputs 0, FSM IDLE, wait counter 0, streak counter 0, err 0.
- States:
  - IDLE: no access in progress.
  - BUSY: access in progress.
- IDLE transitions:
  - Any req high: latch source/address/wr/wdata, go BUSY, counter=MEM_LATENCY-1.
  - No req: stay IDLE.
- Grant rule in IDLE:
  - Only one requester high: grant it.
  - Both high: grant data unless streak==DATA_STREAK_MAX, then grant instruction.
  - Streak counter: increments on a data grant while i_req is high; clears on any instruction grant or when i_req is low at a grant.
- BUSY:
  - mem_en=1; mem_addr/mem_wr/mem_wdata held from the latched values.
  - Counter decrements each cycle.
  - On counter==0: pulse the granted ack, drive the granted rdata from mem_rdata (reads), return to IDLE.
- Latency: single uncontended access acks on cycle MEM_LATENCY after the req is first seen in IDLE.
  - Req sampled cycle 0, ack cycle MEM_LATENCY.
  - No back-to-back grant in the ack cycle; next grant decision occurs in the following IDLE cycle.
- rdata outputs: hold their last value outside ack; reset to 0.
- stall = (i_req & ~i_ack) | (d_req & ~d_ack).
- err set when:
  - granted requester drops req before its ack;
  - d_wr/d_addr change while d_req is high and unacked;
  - i_req and d_req are both high with d_wr=1 and d_addr==i_addr (self-modifying hazard; flagged, still serviced data-first).
- rst mid-BUSY: access abandoned, mem_en low next cycle, no ack issued.
- MEM_LATENCY==1: BUSY lasts one cycle; ack is the cycle after grant.

Optional Feature:
- MEM_ARB_STATS_EN
  - Defined: adds output ports stat_istall [15:0] and stat_dstall [15:0].
  - Each counts cycles its requester's req was high without ack.
  - Saturating at 16'hFFFF; cleared by rst.
  - Not defined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum {ARB_IDLE, ARB_BUSY};
  - source enum {SRC_INSTR, SRC_DATA};
  - width constants ADDR_W_DEF=16, DATA_W_DEF=16.
- One sub-module: arb_wait_counter.
  - Loadable 4-bit down counter with done flag.
  - Reused for access timing and, with saturating mode, for the stats counters.

Test Plan:
- Lone i_req at addr 0x0040, MEM_LATENCY=2, mem_rdata=0xA5A5 -> mem_en cycles 1–2, i_ack cycle 2, i_rdata=0xA5A5, stall high cycles 0–1.
- i_req and d_req (read 0x0100) together -> data granted first: d_ack at cycle 2, i grant at cycle 3, i_ack at cycle 5.
- d_req held continuously with i_req high, DATA_STREAK_MAX=4 -> four d_acks, then one i_ack, then data resumes.
- d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> mem_wr=1 and mem_wdata=0x1234 for 2 cycles, d_ack once, err stays 0.
- d_req dropped one cycle after grant -> err=1 and stays 1; the access still completes with no d_ack.
- rst asserted during BUSY cycle 1 -> next cycle all outputs 0, FSM IDLE, no ack emitted.
